lif_neuron_array: RTL
=====================

LIF_NEURON_ARRAY -- requirements
Module: lif_neuron_array

Interface
REQ-001 SHALL provide parameter N_CH, default 4, number of time-multiplexed neuron channels (2..16).
REQ-002 SHALL provide parameter W, default 8, membrane, current and threshold width.
REQ-003 SHALL provide parameter LEAK_SHIFT, default 2, leak equals V >> LEAK_SHIFT.
REQ-004 SHALL provide parameter REFRAC, default 2, refractory length in accepted samples; 0 disables refractory.
REQ-005 SHALL define CW = max(1, clog2(N_CH)) for all channel-index ports.
REQ-006 clk  input  1  single clock, all state rising-edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 ena  input  1  global enable; low holds all state and forces in_ready low.
REQ-009 in_valid  input  1  input sample valid.
REQ-010 in_ready  output  1  sample accepted when in_valid and in_ready are both high.
REQ-011 in_ch  input  CW  target channel of the sample.
REQ-012 in_cur  input  W  unsigned input current.
REQ-013 thresh  input  W  unsigned firing threshold, shared by all channels.
REQ-014 spike_valid  output  1  spike event pending.
REQ-015 spike_ready  input  1  consumer accepts spike event.
REQ-016 spike_ch  output  CW  channel that fired.
REQ-017 vmem_sel  input  CW  debug channel select.
REQ-018 vmem_out  output  W  combinational membrane value of channel vmem_sel.
REQ-019 cnt_out  output  16  spike count of channel vmem_sel (see Configuration).

Function
REQ-020 in_ready SHALL equal ena AND (NOT spike_valid OR spike_ready).
REQ-021 On accept with channel refractory counter zero: V' = V - (V >> LEAK_SHIFT) + in_cur, computed at W+1 bits, saturated to 2^W-1.
REQ-022 If V' >= thresh the channel SHALL fire: V written 0, refractory counter loaded with REFRAC; otherwise V written V'.
REQ-023 thresh = 0 SHALL make every non-refractory accepted sample fire.
REQ-024 On accept with refractory counter nonzero: counter decrements by 1, V stays 0, no spike, in_cur ignored.
REQ-025 A fire SHALL set spike_valid and spike_ch on the clock edge following acceptance (latency 1 cycle).
REQ-026 spike_valid and spike_ch SHALL hold stable until spike_ready is high; then clear unless a new fire loads the register in the same cycle.
REQ-027 Back-to-back samples to the same channel SHALL each see the previous sample's written state (no stale read).
REQ-028 Unaccepted cycles SHALL not change any channel state.
REQ-029 in_ch >= N_CH SHALL accept and discard the sample with no state change and no spike.

Reset
REQ-030 rst high at a clock edge SHALL clear all V, refractory counters, spike counters, spike_valid and spike_ch to 0, overriding any simultaneous accept.
REQ-031 During and after reset in_ready SHALL follow REQ-020 (high when ena high).

Configuration
REQ-032 Macro LIF_SPIKE_COUNT_EN defined: per-channel 16-bit saturating spike counters, increment on each fire, cnt_out shows channel vmem_sel.
REQ-033 Macro LIF_SPIKE_COUNT_EN undefined: no counters built, cnt_out tied 0.

Verification (W=8, N_CH=4, LEAK_SHIFT=2, REFRAC=2, ena=1 unless stated)
REQ-034 Reset: rst 1 cycle -> all vmem_out 0, spike_valid 0, in_ready 1, cnt_out 0.
REQ-035 Integrate: thresh=100, ch0 in_cur=40 x4 back-to-back -> V 40, 70, 93, then fire; spike_valid=1 spike_ch=0 next cycle, vmem_out(ch0)=0, cnt_out(ch0)=1 with macro.
REQ-036 Refractory: after REQ-035, ch0 in_cur=200 x3 -> first two no spike, V 0; third fires.
REQ-037 Saturation: thresh=255, ch1 in_cur=200 x2 -> V 200, then 350 saturates 255, fires.
REQ-038 Backpressure: spike pending, spike_ready=0 for 5 cycles -> in_ready 0, spike_ch stable, no vmem change; spike_ready=1 -> spike_valid clears, in_ready 1.
REQ-039 Reset mid-operation: ch2 V=93 with spike pending, rst 1 cycle -> V 0, spike_valid 0, counters 0; ena=0 -> in_ready 0 and state held.

Source files
------------

// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons with a one-deep spike output register.
// Define LIF_SPIKE_COUNT_EN to build per-channel 16-bit saturating spike counters on cnt_out.
module lif_neuron_array #(
    parameter int N_CH       = 4,
    parameter int W          = 8,
    parameter int LEAK_SHIFT = 2,
    parameter int REFRAC     = 2,
    localparam int CW        = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int RW        = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_ch,
    input  logic [W-1:0]  in_cur,
    input  logic [W-1:0]  thresh,
    output logic          spike_valid,
    input  logic          spike_ready,
    output logic [CW-1:0] spike_ch,
    input  logic [CW-1:0] vmem_sel,
    output logic [W-1:0]  vmem_out,
    output logic [15:0]   cnt_out
);

    logic [W-1:0]  v_q   [N_CH];
    logic [W-1:0]  v_d   [N_CH];
    logic [RW-1:0] ref_q [N_CH];
    logic [RW-1:0] ref_d [N_CH];
`ifdef LIF_SPIKE_COUNT_EN
    logic [15:0]   cnt_q [N_CH];
    logic [15:0]   cnt_d [N_CH];
`endif
    logic          spike_valid_q, spike_valid_d;
    logic [CW-1:0] spike_ch_q, spike_ch_d;

    logic          accept;
    logic          ch_ok;
    logic          fire;
    logic [W-1:0]  v_cur;
    logic [W:0]    sum_w;
    logic [W-1:0]  v_new;

    assign in_ready = ena & (~spike_valid_q | spike_ready);
    assign accept   = in_valid & in_ready;
    assign ch_ok    = (int'(in_ch) < N_CH);

    // Leak-then-integrate in W+1 bits so the overflow bit drives saturation.
    always_comb begin
        v_cur = ch_ok ? v_q[in_ch] : '0;
        sum_w = {1'b0, v_cur} - {1'b0, (v_cur >> LEAK_SHIFT)} + {1'b0, in_cur};
        v_new = sum_w[W] ? {W{1'b1}} : sum_w[W-1:0];
    end

    always_comb begin
        v_d           = v_q;
        ref_d         = ref_q;
`ifdef LIF_SPIKE_COUNT_EN
        cnt_d         = cnt_q;
`endif
        fire          = 1'b0;
        spike_valid_d = spike_valid_q;
        spike_ch_d    = spike_ch_q;

        if (ena && spike_valid_q && spike_ready) begin
            spike_valid_d = 1'b0;
            spike_ch_d    = '0;
        end

        if (accept && ch_ok) begin
            if (ref_q[in_ch] != '0) begin
                ref_d[in_ch] = ref_q[in_ch] - RW'(1);
                v_d[in_ch]   = '0;
            end else if (v_new >= thresh) begin
                fire         = 1'b1;
                v_d[in_ch]   = '0;
                ref_d[in_ch] = RW'(REFRAC);
`ifdef LIF_SPIKE_COUNT_EN
                if (cnt_q[in_ch] != 16'hFFFF) begin
                    cnt_d[in_ch] = cnt_q[in_ch] + 16'd1;
                end
`endif
            end else begin
                v_d[in_ch] = v_new;
            end
        end

        if (fire) begin
            spike_valid_d = 1'b1;
            spike_ch_d    = in_ch;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                v_q[i]   <= '0;
                ref_q[i] <= '0;
`ifdef LIF_SPIKE_COUNT_EN
                cnt_q[i] <= '0;
`endif
            end
            spike_valid_q <= 1'b0;
            spike_ch_q    <= '0;
        end else begin
            v_q           <= v_d;
            ref_q         <= ref_d;
`ifdef LIF_SPIKE_COUNT_EN
            cnt_q         <= cnt_d;
`endif
            spike_valid_q <= spike_valid_d;
            spike_ch_q    <= spike_ch_d;
        end
    end

    assign spike_valid = spike_valid_q;
    assign spike_ch    = spike_ch_q;
    assign vmem_out    = (int'(vmem_sel) < N_CH) ? v_q[vmem_sel] : '0;
`ifdef LIF_SPIKE_COUNT_EN
    assign cnt_out     = (int'(vmem_sel) < N_CH) ? cnt_q[vmem_sel] : '0;
`else
    assign cnt_out     = '0;
`endif

endmodule
